bpred_unit: RTL and testbench
=============================

# bpred_unit

Parametrised branch-prediction unit for the pipelined RV32 core. It is a two-level adaptive predictor with per-entry pattern tables selected by global history, and a tagged BTB with valid bits. It adds a return-address stack, speculative global-history update at fetch with recovery on mispredict, and configurable table, history and counter sizes. Fetch queries it combinationally; execute resolves into it. All PCs are word addresses, so the sequential next PC is pc+1.

## Interface
- IDX_W, 8: BHT/BTB index bits, giving 2^IDX_W entries indexed by pc[IDX_W-1:0]; the BTB tag is pc[31:IDX_W].
- GHR_W, 2: global history bits; each entry holds 2^GHR_W counters.
- CTR_W, 2: saturating counter width, with CTR_W ≥ 2.
- RAS_DEPTH, 4: return-stack entries; must be a power of two and ≥ 2. RP_W = log2(RAS_DEPTH).
- clk in 1: clock.
- rst in 1: reset, synchronous, active-high.
- f_valid in 1: fetch lookup valid.
- f_pc in 32: fetched PC.
- f_is_br, f_is_jal, f_is_jalr in 1 each: opcode class of the fetched instruction.
- f_is_call, f_is_ret in 1 each: call is jal/jalr with rd=x1; ret is jalr with rs1=x1 and rd=x0.
- p_next_pc out 32: predicted next PC (combinational).
- p_taken out 1: predicted redirect.
- p_ghr out GHR_W: GHR snapshot before this instruction, carried down the pipe.
- p_ras_ptr out RP_W: RAS pointer snapshot before this instruction.
- u_valid in 1: a control-flow instruction resolved in execute.
- u_pc, u_target in 32: resolved PC and actual next PC.
- u_is_br, u_is_call, u_is_ret, u_taken, u_mispred in 1 each: resolved class, outcome, and mispredict flag (computed by the core).
- u_ghr in GHR_W, u_ras_ptr in RP_W: snapshots returned from fetch.
- stat_total, stat_hit, stat_miss out 32: prediction statistics.

## Operation
- State:
  - PHT[2^IDX_W][2^GHR_W] of CTR_W-bit counters.
  - BTB[2^IDX_W] holding {valid, tag, target}.
  - GHR.
  - RAS[RAS_DEPTH] with pointer rp (rp addresses the top of stack).
- Lookup (combinational, only meaningful when f_valid; idx=f_pc[IDX_W-1:0]):
  - hit = BTB[idx].valid && tag == f_pc[31:IDX_W].
  - Conditional branch: p_taken = PHT[idx][GHR][MSB] && hit.
  - jal/jalr that is not a ret: p_taken = hit.
  - Ret: p_taken = 1 and p_next_pc = RAS[rp].
  - All other instructions: p_taken = 0.
  - p_next_pc = p_taken ? (ret ? RAS[rp] : BTB[idx].target) : f_pc+1.
- Speculative update at the clock edge, when f_valid and not u_mispred:
  - f_is_br: GHR ← {GHR[GHR_W-2:0], p_taken}, truncated to GHR_W.
  - f_is_call: rp ← rp+1, then RAS[rp+1] ← f_pc+1.
  - f_is_ret: rp ← rp-1.
  - rp arithmetic is modulo RAS_DEPTH. Overflow overwrites the oldest entry; underflow returns stale data and needs no special handling.
- Resolve (u_valid):
  - u_is_br: PHT[u_pc idx][u_ghr] saturates +1 if u_taken, -1 otherwise.
  - u_taken and not u_is_ret: BTB[u_pc idx] ← {1, u_pc[31:IDX_W], u_target}.
  - u_mispred restores and replays the instruction's own effect:
    - GHR ← u_is_br ? ((u_ghr<<1)|u_taken) truncated to GHR_W : u_ghr.
    - rp ← u_ras_ptr, adjusted by u_is_call (+1, and RAS[u_ras_ptr+1] ← u_pc+1) or u_is_ret (-1).
  - Statistics: stat_total+1; then stat_miss+1 if u_mispred, else stat_hit+1. Counters wrap modulo 2^32.
- Simultaneous events:
  - u_mispred in the same cycle as f_valid: the resolve path wins and the fetch-side GHR/RAS update is dropped (that fetch is being flushed).
  - PHT/BTB read and write to the same entry in the same cycle: the read returns the old value.
- Reset: with rst high at a clock edge:
  - every PHT counter ← 2^(CTR_W-1)-1 (weakly not-taken);
  - every BTB valid ← 0;
  - RAS entries, rp and GHR ← 0;
  - stat_* ← 0.
  - All f_* and u_* inputs are ignored in that cycle.
  - Reset values of the combinational outputs therefore follow: p_ghr=0, p_ras_ptr=0, and p_next_pc=f_pc+1 for everything except ret, which returns 0.

## Timing
- Lookup has zero latency: outputs are combinational from f_* and current state.
- Every state update occurs at posedge clk and is visible to a lookup one cycle later.
- There is no handshake. f_valid and u_valid are single-cycle strobes, and back-to-back strobes are legal every cycle.
- Reset takes effect in one cycle; asserting it mid-operation discards all training.

## Test plan
All scenarios use default parameters.
- **Reset lookup:** reset, then f_pc=0x10, f_is_br. Expect p_taken=0, p_next_pc=0x11, p_ghr=0. Next cycle GHR=0.
- **Training:** u_valid, u_is_br, u_pc=0x10, u_taken=1, u_target=0x40, u_ghr=0, u_mispred=0. Then lookup f_pc=0x10 as a branch. Expect p_taken=1, p_next_pc=0x40, and GHR=01 afterwards.
- **Tag miss:** continuing the training scenario, look up f_pc=0x110 (same index, different tag) as a branch. Expect p_taken=0, p_next_pc=0x111.
- **RAS:**
  - Calls at 0x20 and 0x30, then two rets. Expect 0x31, then 0x21.
  - Five calls at 0x1..0x5, then five rets. Expect 0x6, 0x5, 0x4, 0x3, 0x6.
- **Recovery:**
  - Branch fetched with p_ghr=01 and p_ras_ptr=2, followed by two speculative calls.
  - Then u_mispred with u_is_br, u_taken=0, u_ghr=01, u_ras_ptr=2, and a simultaneous f_is_call.
  - Expect GHR=10, rp=2, and no push.
- **Stats and reset:** 3 resolves with the second mispredicted. Expect total=3, hit=2, miss=1. Assert rst mid-stream: all stats are 0 and the trained entry predicts not-taken.

Source files
------------

// File: rtl/bpred_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : bpred_unit_if
// Purpose  : Fetch / execute / statistics bundle of the branch-prediction
//            unit. The core side uses the master modport and the predictor
//            uses the slave modport.
// Signals  :
//   f_*     fetch lookup request (pc plus opcode class)
//   p_*     combinational prediction plus GHR / RAS-pointer snapshots
//   u_*     execute-stage resolve (outcome, mispredict, returned snapshots)
//   stat_*  prediction statistics (total / hit / miss)
// Revision : 1.0 - initial release
// ============================================================================
interface bpred_unit_if #(
   parameter int GHR_W     = 2,
   parameter int RAS_DEPTH = 4,
   parameter int RP_W      = $clog2(RAS_DEPTH)
);
   // fetch lookup
   logic              f_valid;
   logic [31:0]       f_pc;
   logic              f_is_br;
   logic              f_is_jal;
   logic              f_is_jalr;
   logic              f_is_call;
   logic              f_is_ret;
   // prediction
   logic [31:0]       p_next_pc;
   logic              p_taken;
   logic [GHR_W-1:0]  p_ghr;
   logic [RP_W-1:0]   p_ras_ptr;
   // resolve
   logic              u_valid;
   logic [31:0]       u_pc;
   logic [31:0]       u_target;
   logic              u_is_br;
   logic              u_is_call;
   logic              u_is_ret;
   logic              u_taken;
   logic              u_mispred;
   logic [GHR_W-1:0]  u_ghr;
   logic [RP_W-1:0]   u_ras_ptr;
   // statistics
   logic [31:0]       stat_total;
   logic [31:0]       stat_hit;
   logic [31:0]       stat_miss;

   modport master (
      output f_valid, f_pc, f_is_br, f_is_jal, f_is_jalr, f_is_call, f_is_ret,
      output u_valid, u_pc, u_target, u_is_br, u_is_call, u_is_ret,
             u_taken, u_mispred, u_ghr, u_ras_ptr,
      input  p_next_pc, p_taken, p_ghr, p_ras_ptr,
      input  stat_total, stat_hit, stat_miss
   );

   modport slave (
      input  f_valid, f_pc, f_is_br, f_is_jal, f_is_jalr, f_is_call, f_is_ret,
      input  u_valid, u_pc, u_target, u_is_br, u_is_call, u_is_ret,
             u_taken, u_mispred, u_ghr, u_ras_ptr,
      output p_next_pc, p_taken, p_ghr, p_ras_ptr,
      output stat_total, stat_hit, stat_miss
   );
endinterface
`default_nettype wire

// File: rtl/bpred_unit.sv
`default_nettype none
// ============================================================================
// Module   : bpred_unit
// Purpose  : Two-level adaptive branch predictor for the RV32 core.
//            Per-entry pattern tables (2^GHR_W saturating counters each,
//            selected by global history), a tagged BTB with valid bits, and
//            a return-address stack. GHR and RAS are updated speculatively
//            at fetch and restored from the execute-stage snapshot on a
//            mispredict. All PCs are word addresses (sequential = pc+1).
// Ports    :
//   clk     clock
//   rst     synchronous active-high reset (discards all training)
//   bus     bpred_unit_if.slave: fetch lookup (f_*), prediction (p_*),
//           resolve (u_*), statistics (stat_*)
// Params   : IDX_W (table index bits), GHR_W (history bits), CTR_W (counter
//            width, >= 2), RAS_DEPTH (power of two, >= 2)
// Revision : 1.0 - initial release
// ============================================================================
module bpred_unit #(
   parameter int IDX_W     = 8,
   parameter int GHR_W     = 2,
   parameter int CTR_W     = 2,
   parameter int RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   bpred_unit_if.slave bus
);

   localparam int RP_W   = $clog2(RAS_DEPTH);
   localparam int N_ENT  = 2 ** IDX_W;
   localparam int N_HIST = 2 ** GHR_W;
   localparam int TAG_W  = 32 - IDX_W;

   // weakly not-taken: MSB clear, all lower bits set
   localparam logic [CTR_W-1:0] C_CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
   localparam logic [CTR_W-1:0] C_CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] C_CTR_ZERO = '0;
   localparam logic [CTR_W-1:0] C_CTR_ONE  = CTR_W'(1);
   localparam logic [RP_W-1:0]  C_RP_ONE   = RP_W'(1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   // PHT flattened: entry idx, history h lives at {idx, h}
   logic [CTR_W-1:0] r_pht     [N_ENT*N_HIST];
   logic             r_btb_vld [N_ENT];
   logic [TAG_W-1:0] r_btb_tag [N_ENT];
   logic [31:0]      r_btb_tgt [N_ENT];
   logic [31:0]      r_ras     [RAS_DEPTH];
   logic [RP_W-1:0]  r_rp;
   logic [GHR_W-1:0] r_ghr;
   logic [31:0]      r_stat_total;
   logic [31:0]      r_stat_hit;
   logic [31:0]      r_stat_miss;

   // ------------------------------------------------------------------------
   // Lookup (combinational)
   // ------------------------------------------------------------------------
   logic [IDX_W-1:0] w_f_idx;
   logic             w_f_hit;
   logic [CTR_W-1:0] w_f_ctr;
   logic             w_p_taken;

   assign w_f_idx = bus.f_pc[IDX_W-1:0];
   assign w_f_hit = r_btb_vld[w_f_idx] && (r_btb_tag[w_f_idx] == bus.f_pc[31:IDX_W]);
   assign w_f_ctr = r_pht[{w_f_idx, r_ghr}];

   // ret is checked first: a ret is also a jalr but always redirects to the RAS
   always_comb begin
      w_p_taken = 1'b0;
      if (bus.f_is_ret) begin
         w_p_taken = 1'b1;
      end else if (bus.f_is_br) begin
         w_p_taken = w_f_ctr[CTR_W-1] && w_f_hit;
      end else if (bus.f_is_jal || bus.f_is_jalr) begin
         w_p_taken = w_f_hit;
      end
   end

   assign bus.p_taken   = w_p_taken;
   assign bus.p_next_pc = !w_p_taken   ? (bus.f_pc + 32'd1) :
                          bus.f_is_ret ? r_ras[r_rp] : r_btb_tgt[w_f_idx];
   assign bus.p_ghr     = r_ghr;
   assign bus.p_ras_ptr = r_rp;

   // ------------------------------------------------------------------------
   // GHR / RAS next state: resolve-side recovery overrides the fetch-side
   // speculative update because the fetched instruction is being flushed.
   // ------------------------------------------------------------------------
   logic             w_recover;
   logic [GHR_W:0]   w_f_shift;
   logic [GHR_W:0]   w_u_shift;
   logic [GHR_W-1:0] w_ghr_nxt;
   logic [RP_W-1:0]  w_rp_nxt;
   logic             w_ras_we;
   logic [31:0]      w_ras_wdata;

   assign w_recover = bus.u_valid && bus.u_mispred;
   // one extra bit then truncate, so GHR_W = 1 works as well
   assign w_f_shift = {r_ghr, w_p_taken};
   assign w_u_shift = {bus.u_ghr, bus.u_taken};

   always_comb begin
      w_ghr_nxt   = r_ghr;
      w_rp_nxt    = r_rp;
      w_ras_we    = 1'b0;
      w_ras_wdata = bus.f_pc + 32'd1;
      if (w_recover) begin
         // restore the snapshot, then replay the instruction's own effect
         w_ghr_nxt = bus.u_is_br ? w_u_shift[GHR_W-1:0] : bus.u_ghr;
         w_rp_nxt  = bus.u_ras_ptr;
         if (bus.u_is_call) begin
            w_rp_nxt    = bus.u_ras_ptr + C_RP_ONE;
            w_ras_we    = 1'b1;
            w_ras_wdata = bus.u_pc + 32'd1;
         end else if (bus.u_is_ret) begin
            w_rp_nxt = bus.u_ras_ptr - C_RP_ONE;
         end
      end else if (bus.f_valid) begin
         if (bus.f_is_br) begin
            w_ghr_nxt = w_f_shift[GHR_W-1:0];
         end
         if (bus.f_is_call) begin
            w_rp_nxt = r_rp + C_RP_ONE;
            w_ras_we = 1'b1;
         end else if (bus.f_is_ret) begin
            w_rp_nxt = r_rp - C_RP_ONE;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Resolve-side table training
   // ------------------------------------------------------------------------
   logic [IDX_W-1:0]       w_u_idx;
   logic [IDX_W+GHR_W-1:0] w_u_pht_idx;
   logic [CTR_W-1:0]       w_u_ctr;
   logic [CTR_W-1:0]       w_u_ctr_nxt;
   logic                   w_btb_we;

   assign w_u_idx     = bus.u_pc[IDX_W-1:0];
   assign w_u_pht_idx = {w_u_idx, bus.u_ghr};
   assign w_u_ctr     = r_pht[w_u_pht_idx];
   assign w_btb_we    = bus.u_valid && bus.u_taken && !bus.u_is_ret;

   always_comb begin
      w_u_ctr_nxt = w_u_ctr;
      if (bus.u_taken) begin
         if (w_u_ctr != C_CTR_MAX) w_u_ctr_nxt = w_u_ctr + C_CTR_ONE;
      end else begin
         if (w_u_ctr != C_CTR_ZERO) w_u_ctr_nxt = w_u_ctr - C_CTR_ONE;
      end
   end

   // ------------------------------------------------------------------------
   // Registers with reset
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ghr        <= '0;
         r_rp         <= '0;
         r_stat_total <= '0;
         r_stat_hit   <= '0;
         r_stat_miss  <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
         for (int i = 0; i < N_ENT*N_HIST; i++) r_pht[i] <= C_CTR_INIT;
         for (int i = 0; i < N_ENT; i++) r_btb_vld[i] <= 1'b0;
      end else begin
         r_ghr <= w_ghr_nxt;
         r_rp  <= w_rp_nxt;
         if (w_ras_we) r_ras[w_rp_nxt] <= w_ras_wdata;
         if (bus.u_valid && bus.u_is_br) r_pht[w_u_pht_idx] <= w_u_ctr_nxt;
         if (w_btb_we) r_btb_vld[w_u_idx] <= 1'b1;
         if (bus.u_valid) begin
            r_stat_total <= r_stat_total + 32'd1;
            if (bus.u_mispred) r_stat_miss <= r_stat_miss + 32'd1;
            else               r_stat_hit  <= r_stat_hit + 32'd1;
         end
      end
   end

   // BTB payload: only meaningful under a set valid bit, so no reset needed
   always_ff @(posedge clk) begin
      if (!rst && w_btb_we) begin
         r_btb_tag[w_u_idx] <= bus.u_pc[31:IDX_W];
         r_btb_tgt[w_u_idx] <= bus.u_target;
      end
   end

   assign bus.stat_total = r_stat_total;
   assign bus.stat_hit   = r_stat_hit;
   assign bus.stat_miss  = r_stat_miss;

endmodule
`default_nettype wire

// File: tb/tb_bpred_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpred_unit
// Purpose  : Self-checking bench for bpred_unit: directed scenarios with
//            fixed expectations, then randomized traffic compared every
//            cycle against a behavioural model of the predictor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpred_unit;

   localparam int IDX_W     = 8;
   localparam int GHR_W     = 2;
   localparam int CTR_W     = 2;
   localparam int RAS_DEPTH = 4;
   localparam int N_ENT     = 2 ** IDX_W;
   localparam int N_HIST    = 2 ** GHR_W;
   localparam int CTR_MAX   = 2 ** CTR_W - 1;
   localparam int CTR_HALF  = 2 ** (CTR_W - 1);

   // instruction classes used by the stimulus helpers
   localparam int K_NONE = 0;
   localparam int K_BR   = 1;
   localparam int K_JAL  = 2;
   localparam int K_JALR = 3;
   localparam int K_CALL = 4;
   localparam int K_RET  = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bpred_unit_if #(.GHR_W(GHR_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

   bpred_unit #(
      .IDX_W    (IDX_W),
      .GHR_W    (GHR_W),
      .CTR_W    (CTR_W),
      .RAS_DEPTH(RAS_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit armed    = 1'b0;

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   int          m_pht [N_ENT][N_HIST];
   bit          m_bv  [N_ENT];
   logic [31:0] m_tag [N_ENT];
   logic [31:0] m_tgt [N_ENT];
   logic [31:0] m_ras [RAS_DEPTH];
   int          m_rp, m_ghr;
   logic [31:0] m_tot, m_hit, m_miss;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
      end
   endtask

   function automatic void model_predict(output bit tk, output logic [31:0] np);
      int idx;
      bit hit;
      idx = int'(bus.f_pc % N_ENT);
      hit = m_bv[idx] && (m_tag[idx] == (bus.f_pc >> IDX_W));
      tk  = 1'b0;
      if (bus.f_is_ret)                       tk = 1'b1;
      else if (bus.f_is_br)                   tk = hit && (m_pht[idx][m_ghr] >= CTR_HALF);
      else if (bus.f_is_jal || bus.f_is_jalr) tk = hit;
      if (!tk)              np = bus.f_pc + 1;
      else if (bus.f_is_ret) np = m_ras[m_rp];
      else                  np = m_tgt[idx];
   endfunction

   function automatic void model_edge(input bit tk);
      int idx, g;
      bit mis;
      if (rst) begin
         foreach (m_pht[i, j]) m_pht[i][j] = CTR_HALF - 1;
         foreach (m_bv[i]) m_bv[i] = 1'b0;
         foreach (m_ras[i]) m_ras[i] = '0;
         m_rp = 0; m_ghr = 0; m_tot = 0; m_hit = 0; m_miss = 0;
         return;
      end
      mis = bus.u_valid && bus.u_mispred;
      if (bus.u_valid) begin
         idx = int'(bus.u_pc % N_ENT);
         g   = int'(bus.u_ghr);
         if (bus.u_is_br) begin
            if (bus.u_taken) m_pht[idx][g] = (m_pht[idx][g] == CTR_MAX) ? CTR_MAX : m_pht[idx][g] + 1;
            else             m_pht[idx][g] = (m_pht[idx][g] == 0) ? 0 : m_pht[idx][g] - 1;
         end
         if (bus.u_taken && !bus.u_is_ret) begin
            m_bv[idx]  = 1'b1;
            m_tag[idx] = bus.u_pc >> IDX_W;
            m_tgt[idx] = bus.u_target;
         end
         m_tot++;
         if (bus.u_mispred) m_miss++; else m_hit++;
         if (bus.u_mispred) begin
            m_ghr = bus.u_is_br ? (g * 2 + int'(bus.u_taken)) % N_HIST : g;
            m_rp  = int'(bus.u_ras_ptr);
            if (bus.u_is_call) begin
               m_rp = (m_rp + 1) % RAS_DEPTH;
               m_ras[m_rp] = bus.u_pc + 1;
            end else if (bus.u_is_ret) begin
               m_rp = (m_rp + RAS_DEPTH - 1) % RAS_DEPTH;
            end
         end
      end
      if (bus.f_valid && !mis) begin
         if (bus.f_is_br) m_ghr = (m_ghr * 2 + int'(tk)) % N_HIST;
         if (bus.f_is_call) begin
            m_rp = (m_rp + 1) % RAS_DEPTH;
            m_ras[m_rp] = bus.f_pc + 1;
         end else if (bus.f_is_ret) begin
            m_rp = (m_rp + RAS_DEPTH - 1) % RAS_DEPTH;
         end
      end
   endfunction

   // One clock: sample outputs mid-cycle against the model (and optionally a
   // fixed expectation), then advance model and DUT on the edge.
   task automatic cycle(input bit dir, input bit e_tk, input logic [31:0] e_np);
      bit          tk;
      logic [31:0] np;
      #3;
      model_predict(tk, np);
      if (armed) begin
         if (bus.f_valid) begin
            check_eq("p_taken", 32'(bus.p_taken), 32'(tk));
            check_eq("p_next_pc", bus.p_next_pc, np);
         end
         check_eq("p_ghr", 32'(bus.p_ghr), 32'(m_ghr));
         check_eq("p_ras_ptr", 32'(bus.p_ras_ptr), 32'(m_rp));
         check_eq("stat_total", bus.stat_total, m_tot);
         check_eq("stat_hit", bus.stat_hit, m_hit);
         check_eq("stat_miss", bus.stat_miss, m_miss);
      end
      if (dir) begin
         check_eq("dir_taken", 32'(bus.p_taken), 32'(e_tk));
         check_eq("dir_next_pc", bus.p_next_pc, e_np);
      end
      @(posedge clk);
      model_edge(tk);
      #1;
   endtask

   task automatic idle();
      bus.f_valid = 0; bus.f_pc = '0; bus.f_is_br = 0; bus.f_is_jal = 0;
      bus.f_is_jalr = 0; bus.f_is_call = 0; bus.f_is_ret = 0;
      bus.u_valid = 0; bus.u_pc = '0; bus.u_target = '0; bus.u_is_br = 0;
      bus.u_is_call = 0; bus.u_is_ret = 0; bus.u_taken = 0; bus.u_mispred = 0;
      bus.u_ghr = '0; bus.u_ras_ptr = '0;
   endtask

   task automatic fetch(input logic [31:0] pc, input int cls);
      bus.f_valid   = 1'b1;
      bus.f_pc      = pc;
      bus.f_is_br   = (cls == K_BR);
      bus.f_is_jal  = (cls == K_JAL) || (cls == K_CALL);
      bus.f_is_jalr = (cls == K_JALR) || (cls == K_RET);
      bus.f_is_call = (cls == K_CALL);
      bus.f_is_ret  = (cls == K_RET);
   endtask

   task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input int cls,
                          input bit taken, input bit mis, input int ghr, input int rp);
      bus.u_valid   = 1'b1;
      bus.u_pc      = pc;
      bus.u_target  = tgt;
      bus.u_is_br   = (cls == K_BR);
      bus.u_is_call = (cls == K_CALL);
      bus.u_is_ret  = (cls == K_RET);
      bus.u_taken   = taken;
      bus.u_mispred = mis;
      bus.u_ghr     = GHR_W'(ghr);
      bus.u_ras_ptr = 2'(rp);
   endtask

   task automatic expect_state(input int ghr, input int rp);
      check_eq("ghr_state", 32'(bus.p_ghr), 32'(ghr));
      check_eq("rp_state", 32'(bus.p_ras_ptr), 32'(rp));
   endtask

   task automatic expect_stats(input int t, input int h, input int m);
      check_eq("stat_total_dir", bus.stat_total, 32'(t));
      check_eq("stat_hit_dir", bus.stat_hit, 32'(h));
      check_eq("stat_miss_dir", bus.stat_miss, 32'(m));
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      cycle(1'b0, 1'b0, '0);
      rst = 1'b0;
   endtask

   task automatic rand_inputs();
      int fc, uc;
      fc = $urandom_range(0, 5);
      uc = $urandom_range(0, 3);
      fetch(32'($urandom_range(0, 15)) | (32'($urandom_range(0, 1)) << IDX_W), fc);
      bus.f_valid   = ($urandom_range(0, 3) != 0);
      bus.u_valid   = $urandom_range(0, 1);
      bus.u_pc      = 32'($urandom_range(0, 15)) | (32'($urandom_range(0, 1)) << IDX_W);
      bus.u_target  = 32'($urandom_range(0, 255));
      bus.u_is_br   = (uc == 0);
      bus.u_is_call = (uc == 2);
      bus.u_is_ret  = (uc == 3);
      bus.u_taken   = (uc == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.u_mispred = bus.u_valid && ($urandom_range(0, 4) == 0);
      bus.u_ghr     = GHR_W'($urandom_range(0, N_HIST - 1));
      bus.u_ras_ptr = 2'($urandom_range(0, RAS_DEPTH - 1));
      rst           = ($urandom_range(0, 299) == 0);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      cycle(1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, '0);
      rst   = 1'b0;
      armed = 1'b1;

      // reset lookup
      expect_state(0, 0);
      expect_stats(0, 0, 0);
      fetch(32'h10, K_BR);            cycle(1'b1, 1'b0, 32'h11);
      idle(); expect_state(0, 0);

      // training, then hit, then tag miss on the same index
      resolve(32'h10, 32'h40, K_BR, 1'b1, 1'b0, 0, 0); cycle(1'b0, 1'b0, '0);
      idle(); fetch(32'h10, K_BR);     cycle(1'b1, 1'b1, 32'h40);
      idle(); expect_state(1, 0);
      fetch(32'h110, K_BR);            cycle(1'b1, 1'b0, 32'h111);

      // RAS: two nested calls
      idle(); fetch(32'h20, K_CALL);   cycle(1'b1, 1'b0, 32'h21);
      fetch(32'h30, K_CALL);           cycle(1'b1, 1'b0, 32'h31);
      fetch(32'h50, K_RET);            cycle(1'b1, 1'b1, 32'h31);
      fetch(32'h50, K_RET);            cycle(1'b1, 1'b1, 32'h21);
      // RAS overflow wraps and overwrites the oldest entry
      for (int i = 1; i <= 5; i++) begin
         fetch(32'(i), K_CALL);        cycle(1'b1, 1'b0, 32'(i + 1));
      end
      for (int i = 0; i < 5; i++) begin
         fetch(32'h50, K_RET);
         cycle(1'b1, 1'b1, (i == 4) ? 32'h6 : 32'(6 - i));
      end

      // recovery
      do_reset();
      resolve(32'h0, 32'h0, K_JAL, 1'b1, 1'b1, 1, 2); cycle(1'b0, 1'b0, '0);
      idle(); expect_state(1, 2);
      fetch(32'h80, K_BR);             cycle(1'b1, 1'b0, 32'h81);
      fetch(32'h90, K_CALL);           cycle(1'b1, 1'b0, 32'h91);
      fetch(32'hA0, K_CALL);           cycle(1'b1, 1'b0, 32'hA1);
      idle(); expect_state(2, 0);
      resolve(32'h80, 32'h81, K_BR, 1'b0, 1'b1, 1, 2);
      fetch(32'hB0, K_CALL);           cycle(1'b1, 1'b0, 32'hB1);
      idle(); expect_state(2, 2);
      fetch(32'hC0, K_RET);            cycle(1'b1, 1'b1, 32'h0);

      // statistics, then mid-stream reset discards training
      do_reset();
      resolve(32'h10, 32'h40, K_BR, 1'b1, 1'b0, 0, 0);    cycle(1'b0, 1'b0, '0);
      resolve(32'h200, 32'h300, K_JAL, 1'b1, 1'b1, 0, 0); cycle(1'b0, 1'b0, '0);
      resolve(32'h10, 32'h40, K_BR, 1'b1, 1'b0, 0, 0);    cycle(1'b0, 1'b0, '0);
      idle(); expect_stats(3, 2, 1);
      fetch(32'h10, K_BR);             cycle(1'b1, 1'b1, 32'h40);
      do_reset();
      expect_stats(0, 0, 0);
      expect_state(0, 0);
      fetch(32'h10, K_BR);             cycle(1'b1, 1'b0, 32'h11);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rand_inputs();
         cycle(1'b0, 1'b0, '0);
      end
      rst = 1'b0;
      idle();
      cycle(1'b0, 1'b0, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
